fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC and issues requests on the instruction bus.
- Captures returned instruction words into the fetch output register (pc, raw_instr, valid) that feeds the decode stage's input register.
- Accepts redirects from decode (jr/jump/branch targets) and from the trap path (flush), and discards wrong-path responses.
- At most one bus request outstanding at any time.

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one bus request in flight and fills the decode-facing output register.
// Optional FETCH_MISALIGN_EN: flags a misaligned PC with a nop and f_misalign instead of issuing a request.
module fetch_unit #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] flush_pc,
   input  logic            jr,
   input  logic [XLEN-1:0] pcjr,
   input  logic            jump,
   input  logic [XLEN-1:0] pcjump,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] pcbranch,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            ireq_ready,
   input  logic            iresp_valid,
   input  logic [31:0]     iresp_data,
   output logic            f_valid,
   output logic [XLEN-1:0] f_pc,
   output logic [31:0]     f_raw_instr
`ifdef FETCH_MISALIGN_EN
   ,
   output logic            f_misalign
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              f_valid_q, f_valid_d;
   logic [XLEN-1:0]   f_pc_q, f_pc_d;
   logic [31:0]       f_raw_instr_q, f_raw_instr_d;
   logic              f_misalign_q, f_misalign_d;

   logic              redirect;
   logic              slot_free;
   logic              consume;
   logic              pc_misaligned;
   logic [XLEN-1:0]   target;

   assign redirect  = flush | ((jr | jump | branch_taken) & ~stall);
   assign slot_free = ~f_valid_q | ~stall;
   assign consume   = f_valid_q & ~stall;

`ifdef FETCH_MISALIGN_EN
   assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
   assign pc_misaligned = 1'b0;
`endif

   always_comb begin
      if (flush)
         target = flush_pc;
      else if (jr)
         target = {pcjr[XLEN-1:1], 1'b0};
      else if (jump)
         target = pcjump;
      else
         target = pcbranch;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      f_valid_d     = f_valid_q;
      f_pc_d        = f_pc_q;
      f_raw_instr_d = f_raw_instr_q;
      f_misalign_d  = f_misalign_q;
      ireq_valid    = 1'b0;
      ireq_addr     = pc_q;

      if (consume) begin
         f_valid_d    = 1'b0;
         f_misalign_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (redirect) begin
               pc_d = target;
            end else if (pc_misaligned) begin
               // Misaligned PC parks here, re-presenting the flagged nop until a redirect.
               if (slot_free) begin
                  f_valid_d     = 1'b1;
                  f_pc_d        = pc_q;
                  f_raw_instr_d = NOP_INSTR;
                  f_misalign_d  = 1'b1;
               end
            end else begin
               ireq_valid = slot_free & ~reset;
               if (ireq_valid && ireq_ready)
                  state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d    = target;
               state_d = iresp_valid ? S_IDLE : S_DISCARD;
            end else if (iresp_valid) begin
               f_valid_d     = 1'b1;
               f_pc_d        = pc_q;
               f_raw_instr_d = iresp_data;
               f_misalign_d  = 1'b0;
               pc_d          = pc_q + XLEN'(4);
               state_d       = S_IDLE;
            end
         end
         S_DISCARD: begin
            if (redirect)
               pc_d = target;
            if (iresp_valid)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (redirect) begin
         f_valid_d    = 1'b0;
         f_misalign_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         f_valid_q     <= 1'b0;
         f_pc_q        <= '0;
         f_raw_instr_q <= '0;
         f_misalign_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         f_valid_q     <= f_valid_d;
         f_pc_q        <= f_pc_d;
         f_raw_instr_q <= f_raw_instr_d;
         f_misalign_q  <= f_misalign_d;
      end
   end

   assign f_valid     = f_valid_q;
   assign f_pc        = f_pc_q;
   assign f_raw_instr = f_raw_instr_q;
`ifdef FETCH_MISALIGN_EN
   assign f_misalign  = f_misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-by-cycle directed vectors for fetch_unit: inputs applied after posedge, outputs compared at negedge.
// Under FETCH_MISALIGN_EN the vector table exercises the misaligned-PC path instead.
module tb_fetch_unit;

   localparam logic [63:0] R  = 64'h8000_0000;
   localparam logic [63:0] G1 = 64'h1111_0000_0000_0000;
   localparam logic [63:0] G2 = 64'h2222_0000_0000_0000;
   localparam logic [63:0] G3 = 64'h3333_0000_0000_0000;
   localparam logic [63:0] G4 = 64'h4444_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, jr, jump, branch_taken;
   logic [63:0] flush_pc, pcjr, pcjump, pcbranch;
   logic        ireq_valid, ireq_ready, iresp_valid;
   logic [63:0] ireq_addr;
   logic [31:0] iresp_data;
   logic        f_valid;
   logic [63:0] f_pc;
   logic [31:0] f_raw_instr;
   logic        mis_obs;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .jr           (jr),
      .pcjr         (pcjr),
      .jump         (jump),
      .pcjump       (pcjump),
      .branch_taken (branch_taken),
      .pcbranch     (pcbranch),
      .ireq_valid   (ireq_valid),
      .ireq_addr    (ireq_addr),
      .ireq_ready   (ireq_ready),
      .iresp_valid  (iresp_valid),
      .iresp_data   (iresp_data),
      .f_valid      (f_valid),
      .f_pc         (f_pc),
      .f_raw_instr  (f_raw_instr)
`ifdef FETCH_MISALIGN_EN
      ,
      .f_misalign   (mis_obs)
`endif
   );

`ifndef FETCH_MISALIGN_EN
   assign mis_obs = 1'b0;
`endif

   typedef struct {
      string       name;
      logic        stall, flush, jr, jump, br;
      logic [63:0] tgt;
      logic        rdy, rv;
      logic [31:0] rdata;
      logic        e_iv;
      logic [63:0] e_addr;
      logic        e_fv;
      logic [63:0] e_fpc;
      logic [31:0] e_fi;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   function automatic vec_t mk(input string name, input logic st, input logic fl, input logic j_r,
                               input logic jp, input logic br, input logic [63:0] tgt,
                               input logic rdy, input logic rv, input logic [31:0] rdata,
                               input logic e_iv, input logic [63:0] e_addr, input logic e_fv,
                               input logic [63:0] e_fpc, input logic [31:0] e_fi, input logic e_mis);
      vec_t v;
      v.name = name; v.stall = st; v.flush = fl; v.jr = j_r; v.jump = jp; v.br = br;
      v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
      v.e_iv = e_iv; v.e_addr = e_addr; v.e_fv = e_fv; v.e_fpc = e_fpc; v.e_fi = e_fi;
      v.e_mis = e_mis;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      stall        = v.stall;
      flush        = v.flush;
      jr           = v.jr;
      jump         = v.jump;
      branch_taken = v.br;
      ireq_ready   = v.rdy;
      iresp_valid  = v.rv;
      iresp_data   = v.rdata;
      // Only the highest-priority asserted source carries the real target.
      flush_pc = v.flush ? v.tgt : G1;
      pcjr     = (!v.flush && v.jr) ? v.tgt : G2;
      pcjump   = (!v.flush && !v.jr && v.jump) ? v.tgt : G3;
      pcbranch = (!v.flush && !v.jr && !v.jump && v.br) ? v.tgt : G4;
   endtask

   initial begin
      vec_t idle_v;
      idle_v = mk("idle", 0,0,0,0,0, 64'h0, 0,0, 32'h0, 0,0,0,0,0,0);
      drive(idle_v);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ireq_valid", 64'(ireq_valid), 64'h0);
      check("reset_f_valid", 64'(f_valid), 64'h0);
      check("reset_f_pc", f_pc, 64'h0);
      check("reset_f_raw_instr", 64'(f_raw_instr), 64'h0);
      check("reset_f_misalign", 64'(mis_obs), 64'h0);
      check("reset_ireq_addr", ireq_addr, R);
      reset = 1'b0;

`ifndef FETCH_MISALIGN_EN
      //               name          st fl jr jp br tgt                     rdy rv data          iv addr                   fv fpc                    fi          mis
      vecs.push_back(mk("first_req",   0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R,                     0, 64'h0,                 32'h0,        0));
      vecs.push_back(mk("first_wait",  0,0,0,0,0, 64'h0,                  0,1, 32'h0000_0013, 0, R,                     0, 64'h0,                 32'h0,        0));
      vecs.push_back(mk("first_cap",   0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R+4,                   1, R,                     32'h13,       0));
      vecs.push_back(mk("second_wait", 0,0,0,0,0, 64'h0,                  0,1, 32'h0010_0093, 0, R+4,                   0, R,                     32'h13,       0));
      vecs.push_back(mk("third_req",   0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R+8,                   1, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("jump_in_wait",0,0,0,1,0, R+64'h100,              0,0, 32'h0,         0, R+8,                   0, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("discard_resp",0,0,0,0,0, 64'h0,                  0,1, 32'hDEAD_BEEF, 0, R+64'h100,             0, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("jump_req",    0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R+64'h100,             0, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("jr_with_resp",0,0,1,0,0, R+64'h203,              0,1, 32'h1234_5678, 0, R+64'h100,             0, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("jr_not_ready",0,0,0,0,0, 64'h0,                  0,0, 32'h0,         1, R+64'h202,             0, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("jr_req",      0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R+64'h202,             0, R+4,                   32'h0010_0093,0));
      vecs.push_back(mk("jr_resp",     0,0,0,0,0, 64'h0,                  0,1, 32'h0020_0113, 0, R+64'h202,             0, R+4,                   32'h0010_0093,0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk("stall_hold",1,0,0,0,0, 64'h0,                  1,0, 32'h0,         0, R+64'h206,             1, R+64'h202,             32'h0020_0113,0));
      vecs.push_back(mk("stall_release",0,0,0,0,0, 64'h0,                 1,0, 32'h0,         1, R+64'h206,             1, R+64'h202,             32'h0020_0113,0));
      vecs.push_back(mk("post_stall",  0,0,0,0,0, 64'h0,                  0,1, 32'h0030_0193, 0, R+64'h206,             0, R+64'h202,             32'h0020_0113,0));
      vecs.push_back(mk("flush_prio",  1,1,0,0,1, R+64'h800,              1,0, 32'h0,         0, R+64'h20A,             1, R+64'h206,             32'h0030_0193,0));
      vecs.push_back(mk("flush_req",   0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R+64'h800,             0, R+64'h206,             32'h0030_0193,0));
      vecs.push_back(mk("flush_resp",  0,0,0,0,0, 64'h0,                  0,1, 32'h0000_0013, 0, R+64'h800,             0, R+64'h206,             32'h0030_0193,0));
      vecs.push_back(mk("br_stalled",  1,0,0,0,1, 64'h9000_0000,          1,0, 32'h0,         0, R+64'h804,             1, R+64'h800,             32'h13,       0));
      vecs.push_back(mk("br_idle",     0,0,0,0,1, R+64'h40,               1,0, 32'h0,         0, R+64'h804,             1, R+64'h800,             32'h13,       0));
      vecs.push_back(mk("br_req",      0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, R+64'h40,              0, R+64'h800,             32'h13,       0));
      vecs.push_back(mk("br_resp",     0,0,0,0,0, 64'h0,                  0,1, 32'h0000_0013, 0, R+64'h40,              0, R+64'h800,             32'h13,       0));
      vecs.push_back(mk("flush_top",   0,1,0,0,0, 64'hFFFF_FFFF_FFFF_FFFC,0,0, 32'h0,         0, R+64'h44,              1, R+64'h40,              32'h13,       0));
      vecs.push_back(mk("top_req",     0,0,0,0,0, 64'h0,                  1,0, 32'h0,         1, 64'hFFFF_FFFF_FFFF_FFFC,0, R+64'h40,              32'h13,       0));
      vecs.push_back(mk("top_resp",    0,0,0,0,0, 64'h0,                  0,1, 32'h0000_0073, 0, 64'hFFFF_FFFF_FFFF_FFFC,0, R+64'h40,              32'h13,       0));
      vecs.push_back(mk("wrap_req",    0,0,0,0,0, 64'h0,                  0,0, 32'h0,         1, 64'h0,                 1, 64'hFFFF_FFFF_FFFF_FFFC,32'h73,       0));
      vecs.push_back(mk("consume_only",0,0,0,0,0, 64'h0,                  0,0, 32'h0,         1, 64'h0,                 0, 64'hFFFF_FFFF_FFFF_FFFC,32'h73,       0));
`else
      vecs.push_back(mk("mis_flush",   0,1,0,0,0, R+64'h2,                0,0, 32'h0,         0, R,                     0, 64'h0,                 32'h0,        0));
      vecs.push_back(mk("mis_no_req",  0,0,0,0,0, 64'h0,                  1,0, 32'h0,         0, R+64'h2,               0, 64'h0,                 32'h0,        0));
      vecs.push_back(mk("mis_loaded",  1,0,0,0,0, 64'h0,                  1,0, 32'h0,         0, R+64'h2,               1, R+64'h2,               32'h13,       1));
      vecs.push_back(mk("mis_hold",    0,0,0,0,0, 64'h0,                  1,0, 32'h0,         0, R+64'h2,               1, R+64'h2,               32'h13,       1));
      vecs.push_back(mk("mis_redirect",0,1,0,0,0, R+64'h8,                1,0, 32'h0,         0, R+64'h2,               1, R+64'h2,               32'h13,       1));
      vecs.push_back(mk("mis_cleared", 0,0,0,0,0, 64'h0,                  0,0, 32'h0,         1, R+64'h8,               0, R+64'h2,               32'h13,       0));
`endif

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(negedge clk);
         check({vecs[i].name, "_ireq_valid"}, 64'(ireq_valid), 64'(vecs[i].e_iv));
         check({vecs[i].name, "_ireq_addr"}, ireq_addr, vecs[i].e_addr);
         check({vecs[i].name, "_f_valid"}, 64'(f_valid), 64'(vecs[i].e_fv));
         check({vecs[i].name, "_f_pc"}, f_pc, vecs[i].e_fpc);
         check({vecs[i].name, "_f_raw_instr"}, 64'(f_raw_instr), 64'(vecs[i].e_fi));
         check({vecs[i].name, "_f_misalign"}, 64'(mis_obs), 64'(vecs[i].e_mis));
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
